// File: rtl/demux_1to4_if.sv
// Demux bus: lane select, data and enable in; four data lanes and one-hot lane flags out.
interface demux_1to4_if #(
   parameter int unsigned DATA_W = 1
);
   localparam int unsigned LANES = 4;
   localparam int unsigned SEL_W = 2;
   localparam int unsigned OUT_W = LANES * DATA_W;

   logic [SEL_W-1:0]  Sel;
   logic [DATA_W-1:0] Inp;
   logic              en;
   logic [OUT_W-1:0]  Dout;
   logic [LANES-1:0]  Dvalid;

   modport master (output Sel, Inp, en, input Dout, Dvalid);
   modport slave  (input Sel, Inp, en, output Dout, Dvalid);
endinterface

// File: rtl/demux_1to4.sv
// 1-to-4 demultiplexer: routes Inp onto the lane chosen by Sel, zeros elsewhere,
// with optional output registers (REG_OUT = 1) or a purely combinational path.
module demux_1to4 #(
   parameter int unsigned DATA_W  = 1,
   parameter bit          REG_OUT = 1'b1
) (
   input  logic          clk,
   input  logic          rst_n,
   demux_1to4_if.slave   bus
);
   localparam int unsigned LANES = 4;
   localparam int unsigned SEL_W = 2;
   localparam int unsigned OUT_W = LANES * DATA_W;

   logic [OUT_W-1:0] dout_d;
   logic [LANES-1:0] dvalid_d;

   // Routing: only the selected lane can be nonzero, and only while enabled.
   always_comb begin
      dout_d   = '0;
      dvalid_d = '0;
      if (bus.en) begin
         for (int unsigned i = 0; i < LANES; i++) begin
            if (bus.Sel == SEL_W'(i)) begin
               dout_d[i*DATA_W +: DATA_W] = bus.Inp;
               dvalid_d[i]                = 1'b1;
            end
         end
      end
   end

   if (REG_OUT) begin : g_reg
      logic [OUT_W-1:0] dout_q;
      logic [LANES-1:0] dvalid_q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            dout_q   <= '0;
            dvalid_q <= '0;
         end else begin
            dout_q   <= dout_d;
            dvalid_q <= dvalid_d;
         end
      end

      assign bus.Dout   = dout_q;
      assign bus.Dvalid = dvalid_q;
   end else begin : g_comb
      // Clock and reset have no role on the zero-latency path.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;

      assign bus.Dout   = dout_d;
      assign bus.Dvalid = dvalid_d;
   end
endmodule

// File: tb/tb_demux_1to4.sv
// Directed vector table plus reset/combinational sequences and a random run for demux_1to4.
module tb_demux_1to4;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   demux_1to4_if #(.DATA_W(1)) r_if ();
   demux_1to4_if #(.DATA_W(4)) c_if ();

   demux_1to4 #(.DATA_W(1), .REG_OUT(1'b1)) u_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (r_if.slave)
   );

   demux_1to4 #(.DATA_W(4), .REG_OUT(1'b0)) u_comb (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (c_if.slave)
   );

   typedef struct {
      logic [1:0] sel;
      logic       inp;
      logic       en;
      logic [3:0] dout;
      logic [3:0] dvalid;
   } vec_t;

   vec_t vecs [12];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] ref_model(input logic [1:0] sel, input logic inp, input logic en);
      logic [3:0] d;
      logic [3:0] v;
      d = en ? (4'(inp) << sel) : 4'b0000;
      v = en ? (4'b0001 << sel) : 4'b0000;
      return {d, v};
   endfunction

   task automatic drive_reg(input logic [1:0] sel, input logic inp, input logic en);
      r_if.Sel = sel;
      r_if.Inp = inp;
      r_if.en  = en;
   endtask

   initial begin
      logic [3:0] prev_dout;
      logic [3:0] prev_dvalid;
      logic [7:0] exp;
      logic [1:0] rs;
      logic       ri;
      logic       re;

      vecs[0]  = '{2'd0, 1'b1, 1'b1, 4'b0001, 4'b0001};
      vecs[1]  = '{2'd1, 1'b1, 1'b1, 4'b0010, 4'b0010};
      vecs[2]  = '{2'd2, 1'b1, 1'b1, 4'b0100, 4'b0100};
      vecs[3]  = '{2'd3, 1'b1, 1'b1, 4'b1000, 4'b1000};
      vecs[4]  = '{2'd0, 1'b0, 1'b1, 4'b0000, 4'b0001};
      vecs[5]  = '{2'd1, 1'b0, 1'b1, 4'b0000, 4'b0010};
      vecs[6]  = '{2'd2, 1'b0, 1'b1, 4'b0000, 4'b0100};
      vecs[7]  = '{2'd3, 1'b0, 1'b1, 4'b0000, 4'b1000};
      vecs[8]  = '{2'd2, 1'b1, 1'b0, 4'b0000, 4'b0000};
      vecs[9]  = '{2'd2, 1'b1, 1'b1, 4'b0100, 4'b0100};
      vecs[10] = '{2'd1, 1'b1, 1'b0, 4'b0000, 4'b0000};
      vecs[11] = '{2'd0, 1'b1, 1'b1, 4'b0001, 4'b0001};

      // Reset state, and outputs held at zero across an edge while reset is low
      rst_n = 1'b0;
      drive_reg(2'd0, 1'b0, 1'b0);
      c_if.Sel = 2'd0; c_if.Inp = 4'h0; c_if.en = 1'b0;
      #2;
      check("reset_dout", 32'(r_if.Dout), 32'h0);
      check("reset_dvalid", 32'(r_if.Dvalid), 32'h0);
      drive_reg(2'd3, 1'b1, 1'b1);
      @(posedge clk); #1;
      check("reset_hold_dout", 32'(r_if.Dout), 32'h0);
      check("reset_hold_dvalid", 32'(r_if.Dvalid), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      drive_reg(2'd0, 1'b0, 1'b0);
      prev_dout = 4'b0000;
      prev_dvalid = 4'b0000;

      // Directed table: outputs hold before the edge, update exactly one edge later
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         drive_reg(vecs[i].sel, vecs[i].inp, vecs[i].en);
         #1;
         check($sformatf("v%0d_hold_dout", i), 32'(r_if.Dout), 32'(prev_dout));
         check($sformatf("v%0d_hold_dvalid", i), 32'(r_if.Dvalid), 32'(prev_dvalid));
         @(posedge clk); #1;
         check($sformatf("v%0d_dout", i), 32'(r_if.Dout), 32'(vecs[i].dout));
         check($sformatf("v%0d_dvalid", i), 32'(r_if.Dvalid), 32'(vecs[i].dvalid));
         prev_dout = vecs[i].dout;
         prev_dvalid = vecs[i].dvalid;
      end

      // Mid-stream asynchronous reset clears lane 3 between edges
      @(negedge clk);
      drive_reg(2'd3, 1'b1, 1'b1);
      @(posedge clk); #1;
      check("pre_rst_dout", 32'(r_if.Dout), 32'h8);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("async_rst_dout", 32'(r_if.Dout), 32'h0);
      check("async_rst_dvalid", 32'(r_if.Dvalid), 32'h0);
      c_if.Sel = 2'd1; c_if.Inp = 4'h7; c_if.en = 1'b1;
      #1;
      check("comb_in_reset_dout", 32'(c_if.Dout), 32'h0070);
      check("comb_in_reset_dvalid", 32'(c_if.Dvalid), 32'h2);
      @(negedge clk);
      rst_n = 1'b1;
      drive_reg(2'd1, 1'b1, 1'b1);
      #1;
      check("post_rst_no_stale", 32'(r_if.Dout), 32'h0);
      @(posedge clk); #1;
      check("post_rst_dout", 32'(r_if.Dout), 32'h2);
      check("post_rst_dvalid", 32'(r_if.Dvalid), 32'h2);

      // Combinational instance: zero-latency routing of a 4-bit value
      c_if.Sel = 2'd3; c_if.Inp = 4'hA; c_if.en = 1'b1;
      #1;
      check("comb_sel3_dout", 32'(c_if.Dout), 32'hA000);
      check("comb_sel3_dvalid", 32'(c_if.Dvalid), 32'h8);
      c_if.Sel = 2'd0; c_if.Inp = 4'h5;
      #1;
      check("comb_sel0_dout", 32'(c_if.Dout), 32'h0005);
      check("comb_sel0_dvalid", 32'(c_if.Dvalid), 32'h1);
      c_if.Sel = 2'd2; c_if.Inp = 4'hF; c_if.en = 1'b0;
      #1;
      check("comb_dis_dout", 32'(c_if.Dout), 32'h0);
      check("comb_dis_dvalid", 32'(c_if.Dvalid), 32'h0);

      // Random traffic against the reference model, one cycle delayed
      for (int n = 0; n < 1000; n++) begin
         @(negedge clk);
         rs = 2'($urandom_range(3));
         ri = 1'($urandom_range(1));
         re = 1'($urandom_range(1));
         drive_reg(rs, ri, re);
         exp = ref_model(rs, ri, re);
         @(posedge clk); #1;
         check($sformatf("rnd%0d_dout", n), 32'(r_if.Dout), 32'(exp[7:4]));
         check($sformatf("rnd%0d_dvalid", n), 32'(r_if.Dvalid), 32'(exp[3:0]));
         check($sformatf("rnd%0d_onehot", n), 32'($countones(r_if.Dvalid) <= 1), 32'h1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
